// File: rtl/demux_1a4_fase_pkg.sv
// demux_1a4_fase_pkg: shared widths, lane count and slot encodings for the 1-to-4 deserializer
package demux_1a4_fase_pkg;
    localparam int BW_DEF = 8;
    localparam int CW_DEF = 8;
    localparam int LANES = 4;
    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;
endpackage

// File: rtl/demux_1a4_fase_if.sv
// demux_1a4_fase_if: serial input stream (dataIn/validIn/sync) and parallel lane outputs (dataOut*, validOut*, frameStrobe, frameCount, slot)
interface demux_1a4_fase_if import demux_1a4_fase_pkg::*; #(
    parameter int BW = BW_DEF,
    parameter int CW = CW_DEF
);
    logic [BW-1:0] dataIn;
    logic          validIn;
    logic          sync;
    logic [BW-1:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic          validOut0, validOut1, validOut2, validOut3;
    logic          frameStrobe;
    logic [CW-1:0] frameCount;
    logic [1:0]    slot;
    modport master (
        output dataIn, validIn, sync,
        input  dataOut0, dataOut1, dataOut2, dataOut3,
        input  validOut0, validOut1, validOut2, validOut3,
        input  frameStrobe, frameCount, slot
    );
    modport slave (
        input  dataIn, validIn, sync,
        output dataOut0, dataOut1, dataOut2, dataOut3,
        output validOut0, validOut1, validOut2, validOut3,
        output frameStrobe, frameCount, slot
    );
endinterface

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: mod-4 slot counter with sync override; ports clk, reset, sync in; slot, s_eff, load out
module demux_slot_ctr import demux_1a4_fase_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    output logic [1:0] slot,
    output logic [1:0] s_eff,
    output logic       load
);
    always_comb begin
        s_eff = sync ? SLOT0 : slot;
        load  = s_eff == SLOT3;
    end
    // counting from s_eff makes sync realign to slot 1 next, and is a no-op when already at slot 0
    always_ff @(posedge clk or posedge reset)
        if (reset) slot <= SLOT0;
        else slot <= s_eff + 2'd1;
endmodule

// File: rtl/demux_1a4_fase.sv
// demux_1a4_fase: 1-to-4 byte deserializer; ports clk, reset, bus (slave: serial in, four registered lanes, frame strobe/count, slot)
module demux_1a4_fase import demux_1a4_fase_pkg::*; #(
    parameter int BW = BW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    demux_1a4_fase_if.slave      bus
);
    logic [1:0]    slot, s_eff;
    logic          load;
    logic [BW-1:0] hold_d [3];
    logic [2:0]    hold_v;
    logic [BW-1:0] dout [LANES];
    logic [LANES-1:0] vout;
    logic          fs;
    logic [CW-1:0] fc;
    demux_slot_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .sync  (bus.sync),
        .slot  (slot),
        .s_eff (s_eff),
        .load  (load)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v <= '0;
            vout   <= '0;
            fs     <= 1'b0;
            fc     <= '0;
            for (int n = 0; n < 3; n++) hold_d[n] <= '0;
            for (int n = 0; n < LANES; n++) dout[n] <= '0;
        end else begin
            fs <= load;
            if (load) begin
                // lane 3 bypasses the holding registers and loads straight from the input
                vout <= {bus.validIn, hold_v};
                for (int n = 0; n < 3; n++) if (hold_v[n]) dout[n] <= hold_d[n];
                if (bus.validIn) dout[3] <= bus.dataIn;
                if (fc != '1) fc <= fc + CW'(1);
                hold_v <= '0;
            end else begin
                hold_v[s_eff] <= bus.validIn;
                if (bus.validIn) hold_d[s_eff] <= bus.dataIn;
                // a realigning sync drops whatever partial frame was collected
                if (bus.sync) hold_v[2:1] <= '0;
            end
        end
    end
    assign bus.dataOut0    = dout[0];
    assign bus.dataOut1    = dout[1];
    assign bus.dataOut2    = dout[2];
    assign bus.dataOut3    = dout[3];
    assign bus.validOut0   = vout[0];
    assign bus.validOut1   = vout[1];
    assign bus.validOut2   = vout[2];
    assign bus.validOut3   = vout[3];
    assign bus.frameStrobe = fs;
    assign bus.frameCount  = fc;
    assign bus.slot        = slot;
endmodule

// File: tb/tb_demux_1a4_fase.sv
// tb_demux_1a4_fase: scoreboard bench for demux_1a4_fase with a CW=8 and a CW=2 instance sharing one stream
module tb_demux_1a4_fase;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
        logic [7:0]  c;
        logic [1:0]  c2;
        int unsigned at;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned pos = 0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    logic [31:0] md = '0;
    int mc = 0;
    demux_1a4_fase_if #(.BW(8), .CW(8)) bus ();
    demux_1a4_fase_if #(.BW(8), .CW(2)) bus2 ();
    demux_1a4_fase #(.BW(8), .CW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    demux_1a4_fase #(.BW(8), .CW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    assign bus2.dataIn  = bus.dataIn;
    assign bus2.validIn = bus.validIn;
    assign bus2.sync    = bus.sync;
    always #5 clk = ~clk;
    always @(posedge clk) pos <= pos + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] douts();
        return {bus.dataOut3, bus.dataOut2, bus.dataOut1, bus.dataOut0};
    endfunction
    function automatic logic [3:0] vouts();
        return {bus.validOut3, bus.validOut2, bus.validOut1, bus.validOut0};
    endfunction
    always @(negedge clk) begin
        if (!reset && bus.frameStrobe) begin
            chk("strobe_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("data", 64'(douts()), 64'(e.d));
                chk("valid", 64'(vouts()), 64'(e.v));
                chk("count", 64'(bus.frameCount), 64'(e.c));
                chk("count_cw2", 64'(bus2.frameCount), 64'(e.c2));
                chk("strobe_cycle", 64'(pos), 64'(e.at));
                chk("strobe_cw2", 64'(bus2.frameStrobe), 64'd1);
            end
        end
    end
    task automatic step(input logic [7:0] d, input logic v, input logic s);
        bus.dataIn = d;
        bus.validIn = v;
        bus.sync = s;
        @(negedge clk);
    endtask
    task automatic frame(input logic [31:0] d, input logic [3:0] v, input logic s0);
        exp_t e;
        for (int n = 0; n < 4; n++) if (v[n]) md[n*8 +: 8] = d[n*8 +: 8];
        mc = (mc == 255) ? 255 : mc + 1;
        e.d = md;
        e.v = v;
        e.c = 8'(mc);
        e.c2 = 2'((mc > 3) ? 3 : mc);
        e.at = pos + 4;
        q.push_back(e);
        for (int n = 0; n < 4; n++) step(d[n*8 +: 8], v[n], s0 && n == 0);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, 64'(douts()), 64'd0);
        chk({tag, "_valid"}, 64'(vouts()), 64'd0);
        chk({tag, "_strobe"}, 64'(bus.frameStrobe), 64'd0);
        chk({tag, "_count"}, 64'(bus.frameCount), 64'd0);
        chk({tag, "_slot"}, 64'(bus.slot), 64'd0);
    endtask
    initial begin
        bus.dataIn = '0;
        bus.validIn = 1'b0;
        bus.sync = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        frame(32'hA3A2A1A0, 4'hF, 1'b0);
        frame(32'hFFB2FFB0, 4'b0101, 1'b0);
        frame(32'hA3A2A1A0, 4'hF, 1'b0);
        frame(32'hA3A2A1A0, 4'hF, 1'b0);
        step(8'hA0, 1'b1, 1'b0);
        step(8'hA1, 1'b1, 1'b0);
        chk("slot_before_sync", 64'(bus.slot), 64'd2);
        frame(32'hC3C2C1C0, 4'hF, 1'b1);
        frame(32'hEEEEEEEE, 4'h0, 1'b0);
        frame(32'h13121110, 4'hF, 1'b1);
        step(8'hD0, 1'b1, 1'b0);
        step(8'hD1, 1'b1, 1'b0);
        chk("slot_mid_frame", 64'(bus.slot), 64'd2);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        chk("async_reset_cw2", 64'(bus2.frameCount), 64'd0);
        md = '0;
        mc = 0;
        @(negedge clk);
        reset = 1'b0;
        chk("slot_after_release", 64'(bus.slot), 64'd0);
        frame(32'h55443322, 4'b1000, 1'b0);
        for (int i = 0; i < 20; i++) frame($urandom, 4'($urandom), 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
